// File: rtl/slave_pkg.sv
// Shared constants and types for the slave_pack beat packer.
package slave_pkg;

    localparam int NUM_DEF   = 8;
    localparam int RATIO_DEF = 4;

    function automatic int cw_f(input int ratio);
        return $clog2(ratio + 1);
    endfunction

    typedef enum logic {
        EMPTY,
        FILL
    } fill_st_t;

endpackage

// File: rtl/pack_out_reg.sv
// Output word register with valid/ready hold and a wrapping word counter.
module pack_out_reg
    import slave_pkg::*;
#(
    parameter int W  = 32,
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [W-1:0]  load_data,
    input  logic [CW-1:0] load_bytes,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [W-1:0]  data_out,
    output logic [CW-1:0] out_bytes,
    output logic [15:0]   word_cnt,
    output logic          free
);

    logic          valid_q, valid_d;
    logic [W-1:0]  data_q, data_d;
    logic [CW-1:0] bytes_q, bytes_d;
    logic [15:0]   word_cnt_q, word_cnt_d;

    assign free = !valid_q || out_ready;

    always_comb begin
        valid_d    = valid_q;
        data_d     = data_q;
        bytes_d    = bytes_q;
        word_cnt_d = word_cnt_q;
        if (valid_q && out_ready) begin
            valid_d    = 1'b0;
            word_cnt_d = word_cnt_q + 16'd1;
        end
        // A load in the drain cycle overrides the clear: back-to-back words
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
            bytes_d = load_bytes;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= 1'b0;
            data_q     <= '0;
            bytes_q    <= '0;
            word_cnt_q <= '0;
        end else begin
            valid_q    <= valid_d;
            data_q     <= data_d;
            bytes_q    <= bytes_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    assign out_valid = valid_q;
    assign data_out  = data_q;
    assign out_bytes = bytes_q;
    assign word_cnt  = word_cnt_q;

endmodule

// File: rtl/slave_pack.sv
// Packs RATIO little-endian NUM-bit beats into one word; flush emits a
// zero-padded partial word.
module slave_pack
    import slave_pkg::*;
#(
    parameter int NUM   = NUM_DEF,
    parameter int RATIO = RATIO_DEF,
    parameter int CW    = cw_f(RATIO)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid,
    output logic                 ready,
    input  logic [NUM-1:0]       data_in,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NUM*RATIO-1:0] data_out,
    output logic [CW-1:0]        out_bytes,
    output logic [15:0]          word_cnt
);

    localparam int W = NUM * RATIO;

    logic [W-1:0]  acc_q, acc_d, acc_w;
    logic [CW-1:0] cnt_q, cnt_d, cnt_w;
    logic          flush_pend_q, flush_pend_d;
    logic          free, xfer, last, complete, flush_take;
    logic          load;
    logic [W-1:0]  load_data;
    logic [CW-1:0] load_bytes;
    fill_st_t      st;

    assign st    = (cnt_q == '0) ? EMPTY : FILL;
    assign last  = (cnt_q == CW'(RATIO - 1));
    assign ready = !flush_pend_q && (!last || free);
    assign xfer  = valid && ready;

    assign complete   = xfer && last;
    assign flush_take = flush && (cnt_q != '0 || xfer) && !complete;

    always_comb begin
        acc_w = acc_q;
        cnt_w = cnt_q;
        if (xfer) begin
            acc_w[int'(cnt_q)*NUM +: NUM] = data_in;
            cnt_w = cnt_q + CW'(1);
        end
    end

    always_comb begin
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        flush_pend_d = flush_pend_q;
        load         = 1'b0;
        load_data    = '0;
        load_bytes   = '0;
        // ready already guarantees a free output for the completing beat
        if (complete) begin
            load       = 1'b1;
            load_data  = acc_w;
            load_bytes = CW'(RATIO);
            acc_d      = '0;
            cnt_d      = '0;
        end else if (flush_pend_q) begin
            if (free) begin
                load         = 1'b1;
                load_data    = acc_q;
                load_bytes   = cnt_q;
                acc_d        = '0;
                cnt_d        = '0;
                flush_pend_d = 1'b0;
            end
        end else if (flush_take) begin
            if (free) begin
                load       = 1'b1;
                load_data  = acc_w;
                load_bytes = cnt_w;
                acc_d      = '0;
                cnt_d      = '0;
            end else begin
                acc_d        = acc_w;
                cnt_d        = cnt_w;
                flush_pend_d = 1'b1;
            end
        end else if (xfer) begin
            acc_d = acc_w;
            cnt_d = cnt_w;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q        <= '0;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    pack_out_reg #(
        .W  (W),
        .CW (CW)
    ) u_out (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_data  (load_data),
        .load_bytes (load_bytes),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .data_out   (data_out),
        .out_bytes  (out_bytes),
        .word_cnt   (word_cnt),
        .free       (free)
    );

    a_pend_has_data: assert property (
        @(posedge clk) disable iff (rst) flush_pend_q |-> st == FILL
    );

endmodule

// File: tb/tb_slave_pack.sv
// Table-driven and scoreboard bench for slave_pack.
module tb_slave_pack;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic        ready;
    logic [7:0]  data_in = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] data_out;
    logic [2:0]  out_bytes;
    logic [15:0] word_cnt;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] d;
        logic [2:0]  b;
    } exp_t;

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        fl;
        logic        push;
        logic [31:0] ed;
        logic [2:0]  eb;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[27];

    slave_pack #(
        .NUM   (8),
        .RATIO (4),
        .CW    (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .valid     (valid),
        .ready     (ready),
        .data_in   (data_in),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .out_bytes (out_bytes),
        .word_cnt  (word_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic [2:0] b);
        exp_t e;
        e.d = d;
        e.b = b;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_word", data_out, 32'hDEAD_0000);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("word_data", data_out, e.d);
                chk("word_bytes", 32'(out_bytes), 32'(e.b));
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic fl,
                        output int waits);
        bit got;
        got = 1'b0;
        waits = 0;
        valid = 1'b1;
        data_in = d;
        flush = fl;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (ready) begin
                got = 1'b1;
                break;
            end
            waits++;
        end
        if (!got) chk("send_timeout", 32'(ready), 32'd1);
        @(posedge clk);
        #1;
        valid = 1'b0;
        flush = 1'b0;
    endtask

    task automatic flush_only();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (sb.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) chk("drain_timeout", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        int idx;
        bit acc;

        tbl = '{
            '{1'b1, 8'h11, 1'b0, 1'b0, 32'h0, 3'd0},
            '{1'b1, 8'h22, 1'b0, 1'b0, 32'h0, 3'd0},
            '{1'b1, 8'h33, 1'b0, 1'b0, 32'h0, 3'd0},
            '{1'b1, 8'h44, 1'b0, 1'b1, 32'h44332211, 3'd4},
            '{1'b1, 8'h01, 1'b0, 1'b0, 32'h0, 3'd0},
            '{1'b1, 8'h02, 1'b0, 1'b0, 32'h0, 3'd0},
            '{1'b1, 8'h03, 1'b0, 1'b0, 32'h0, 3'd0},
            '{1'b1, 8'h04, 1'b0, 1'b1, 32'h04030201, 3'd4},
            '{1'b1, 8'h05, 1'b0, 1'b0, 32'h0, 3'd0},
            '{1'b1, 8'h06, 1'b0, 1'b0, 32'h0, 3'd0},
            '{1'b1, 8'h07, 1'b0, 1'b0, 32'h0, 3'd0},
            '{1'b1, 8'h08, 1'b0, 1'b1, 32'h08070605, 3'd4},
            '{1'b1, 8'h09, 1'b0, 1'b0, 32'h0, 3'd0},
            '{1'b1, 8'h0A, 1'b0, 1'b0, 32'h0, 3'd0},
            '{1'b1, 8'h0B, 1'b0, 1'b0, 32'h0, 3'd0},
            '{1'b1, 8'h0C, 1'b0, 1'b1, 32'h0C0B0A09, 3'd4},
            '{1'b1, 8'hAA, 1'b0, 1'b0, 32'h0, 3'd0},
            '{1'b1, 8'hBB, 1'b1, 1'b1, 32'h0000BBAA, 3'd2},
            '{1'b1, 8'hCC, 1'b0, 1'b0, 32'h0, 3'd0},
            '{1'b1, 8'hDD, 1'b0, 1'b0, 32'h0, 3'd0},
            '{1'b0, 8'h00, 1'b1, 1'b1, 32'h0000DDCC, 3'd2},
            '{1'b1, 8'h55, 1'b0, 1'b0, 32'h0, 3'd0},
            '{1'b1, 8'h56, 1'b0, 1'b0, 32'h0, 3'd0},
            '{1'b1, 8'h57, 1'b0, 1'b0, 32'h0, 3'd0},
            '{1'b1, 8'h58, 1'b1, 1'b1, 32'h58575655, 3'd4},
            '{1'b1, 8'h66, 1'b0, 1'b0, 32'h0, 3'd0},
            '{1'b0, 8'h00, 1'b1, 1'b1, 32'h00000066, 3'd1}
        };

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_data_out", data_out, 32'd0);
        chk("rst_out_bytes", 32'(out_bytes), 32'd0);
        chk("rst_word_cnt", 32'(word_cnt), 32'd0);
        chk("rst_ready", 32'(ready), 32'd1);
        @(posedge clk);
        #1;

        out_ready = 1'b1;
        foreach (tbl[i]) begin
            if (tbl[i].push) push(tbl[i].ed, tbl[i].eb);
            if (tbl[i].v) begin
                send(tbl[i].d, tbl[i].fl, w);
                chk("ready_held", 32'(w), 32'd0);
            end else begin
                flush_only();
            end
        end
        drain();
        chk("word_cnt_tbl", 32'(word_cnt), 32'd8);

        flush_only();
        @(negedge clk);
        chk("empty_flush_1", 32'(out_valid), 32'd0);
        flush_only();
        @(negedge clk);
        chk("empty_flush_2", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

        // Backpressure: 8 beats offered, output stalled
        out_ready = 1'b0;
        push(32'h04030201, 3'd4);
        push(32'h08070605, 3'd4);
        idx = 0;
        valid = 1'b1;
        data_in = 8'h01;
        repeat (10) begin
            @(negedge clk);
            acc = ready;
            @(posedge clk);
            #1;
            if (acc) idx++;
            data_in = 8'(idx + 1);
            valid = (idx < 8);
        end
        chk("bp_accepted", 32'(idx), 32'd7);
        @(negedge clk);
        chk("bp_ready_low", 32'(ready), 32'd0);
        chk("bp_hold_valid", 32'(out_valid), 32'd1);
        chk("bp_hold_data", data_out, 32'h04030201);
        chk("bp_hold_bytes", 32'(out_bytes), 32'd4);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_ready_free", 32'(ready), 32'd1);
        @(posedge clk);
        #1;
        valid = 1'b0;
        drain();
        chk("word_cnt_bp", 32'(word_cnt), 32'd10);

        // Flush while the output is stalled
        out_ready = 1'b0;
        push(32'h14131211, 3'd4);
        push(32'h00232221, 3'd3);
        send(8'h11, 1'b0, w);
        send(8'h12, 1'b0, w);
        send(8'h13, 1'b0, w);
        send(8'h14, 1'b0, w);
        send(8'h21, 1'b0, w);
        send(8'h22, 1'b0, w);
        send(8'h23, 1'b0, w);
        flush_only();
        @(negedge clk);
        chk("fp_ready_low1", 32'(ready), 32'd0);
        @(negedge clk);
        chk("fp_ready_low2", 32'(ready), 32'd0);
        chk("fp_hold_data", data_out, 32'h14131211);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();
        chk("fp_ready_back", 32'(ready), 32'd1);

        // Reset with a partial word and a held output
        out_ready = 1'b0;
        send(8'h41, 1'b0, w);
        send(8'h42, 1'b0, w);
        send(8'h43, 1'b0, w);
        send(8'h44, 1'b0, w);
        send(8'h45, 1'b0, w);
        send(8'h46, 1'b0, w);
        @(negedge clk);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_data", data_out, 32'd0);
        chk("mid_rst_bytes", 32'(out_bytes), 32'd0);
        chk("mid_rst_wcnt", 32'(word_cnt), 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        push(32'h34333231, 3'd4);
        send(8'h31, 1'b0, w);
        send(8'h32, 1'b0, w);
        send(8'h33, 1'b0, w);
        send(8'h34, 1'b0, w);
        drain();
        chk("post_rst_wcnt", 32'(word_cnt), 32'd1);

        // word_cnt wrap
        force dut.u_out.word_cnt_q = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.u_out.word_cnt_q;
        push(32'h54535251, 3'd4);
        send(8'h51, 1'b0, w);
        send(8'h52, 1'b0, w);
        send(8'h53, 1'b0, w);
        send(8'h54, 1'b0, w);
        drain();
        chk("wcnt_wrap", 32'(word_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
